tick_serializer: RTL and testbench
==================================

Name: tick_serializer

Overview:
- Frame serializer advanced only by a one-cycle clock-enable strobe (clk_flag) from the clock-divider stage; it never uses a derived clock.
- Accepts a parallel word over a valid/ready handshake and shifts it out as an asynchronous-serial frame: start bit, data LSB first, optional parity, stop bit.
- Sits directly downstream of the divider. clk_flag sets the bit-time granularity.

Parameters:
- DATA_W, 8, data bits per frame (legal range 5..9).
- TICKS_PER_BIT, 16, clk_flag strobes per serial bit (minimum 1).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- sys_clk  input  1  system clock; all logic is on the rising edge.
- sys_rst  input  1  asynchronous reset, active-high.
- clk_flag  input  1  enable strobe, one sys_clk cycle wide, from the divider.
- tx_data  input  DATA_W  word to send; sampled only on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles at 1.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Interface: one clock (sys_clk). Reset is asynchronous and active-high (sys_rst). All outputs are registered.
- Reset values: tx_out = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, state = IDLE, tick and bit counters = 0, shift register = 0.
- Reset asserted mid-frame: the frame is aborted immediately and all outputs return to their reset values. Nothing is resumed after reset releases.
- States:
  - IDLE: tx_ready = 1. Accept occurs when tx_valid = 1 and tx_ready = 1. On accept, latch tx_data, compute parity, clear counters and go to START.
  - Registered effect of accept: on the next cycle tx_out = 0, tx_busy = 1, tx_ready = 0.
  - START, then DATA (DATA_W bits), then PARITY (only if PARITY_EN = 1), then STOP, then IDLE.
- Bit timing:
  - The tick counter increments on each clk_flag = 1 cycle while not in IDLE.
  - A bit ends on the clk_flag cycle where tick count = TICKS_PER_BIT-1. The counter then wraps to 0 and the next bit's value appears on tx_out the following cycle.
  - A clk_flag on the accept cycle is not counted.
  - While clk_flag stays low, tx_out and all state are frozen.
- DATA: shift right and output bit 0 first. A bit counter 0..DATA_W-1 selects the exit to PARITY or STOP.
- Parity: even parity = XOR of the data bits; odd parity = its inverse. The value is computed from the latched word.
- STOP:
  - tx_out = 1.
  - When the stop bit ends, tx_done pulses for exactly 1 cycle. In that same registered update, tx_busy = 0 and tx_ready = 1.
  - Back-to-back: a tx_valid held high is accepted on the first cycle tx_ready = 1. The new start bit follows with no idle gap beyond that 1 cycle.
- Ignored inputs: tx_valid while tx_ready = 0 is ignored. Changes to tx_data after accept have no effect on the frame in progress.
- Bit duration: every bit lasts exactly TICKS_PER_BIT strobes. With a periodic strobe of period P cycles, each bit occupies TICKS_PER_BIT*P cycles, ±P for the first bit only (alignment of the accept cycle to the strobe phase).
- Frame length: 2 + DATA_W + PARITY_EN bits.

Test Plan:
- Reset then idle: assert sys_rst, release, clk_flag every 6 cycles, tx_valid = 0 for 500 cycles -> tx_out = 1, tx_ready = 1, tx_busy = 0 and tx_done = 0 throughout.
- Basic frame: defaults, clk_flag every 6 cycles, send tx_data = 0xA5.
  - Line sequence: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop).
  - Each bit lasts 96 cycles (±6 for the start bit).
  - One tx_done pulse after about 960 cycles, with tx_ready = 1 in the same cycle.
- Parity: PARITY_EN = 1, send 0xA5.
  - PARITY_ODD = 0 -> parity bit 0.
  - PARITY_ODD = 1 -> parity bit 1.
  - Frame is 11 bits; send 0x07 with even parity -> parity bit 1.
- Handshake: tx_valid held high with 0x3C then 0xC3.
  - Both frames are sent back-to-back.
  - tx_ready is high for exactly 1 cycle between them.
  - Toggling tx_data mid-frame does not alter the line.
- Stall and reset: hold clk_flag low for 200 cycles mid-DATA -> tx_out is unchanged and the frame resumes correctly. Then assert sys_rst mid-frame -> the same cycle (asynchronously) gives tx_out = 1, tx_busy = 0, tx_ready = 1, and no tx_done pulse.
- Edge parameters: TICKS_PER_BIT = 1 with clk_flag high every cycle -> one bit per cycle, and 0xFF yields the sequence 0, eight 1s, 1. Also DATA_W = 5 sending 0x15 yields 0,1,0,1,0,1,1.

Source files
------------

// File: rtl/tick_serializer_if.sv
// tick_serializer_if -- parallel word handshake into the tick serializer.
//
// Signals:
//   tx_data   word to send, sampled by the slave only on accept
//   tx_valid  master has a word available
//   tx_ready  slave can take a word this cycle
//
// Modports:
//   master  the word source (drives tx_data/tx_valid, observes tx_ready)
//   slave   the serializer   (observes tx_data/tx_valid, drives tx_ready)
interface tick_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/tick_serializer.sv
// tick_serializer -- async-serial frame transmitter paced by a clock-enable
// strobe from the upstream divider (no derived clocks).
//
// Frame on tx_out: start (0), DATA_W data bits LSB first, optional parity,
// stop (1). Every bit lasts exactly TICKS_PER_BIT clk_flag strobes.
//
// Ports:
//   sys_clk   system clock, rising edge
//   sys_rst   asynchronous reset, active-high
//   clk_flag  one-cycle enable strobe from the divider
//   bus       word handshake (slave side): tx_data, tx_valid, tx_ready
//   tx_out    serial line, idles high
//   tx_busy   frame in progress
//   tx_done   one-cycle pulse when the stop bit ends
module tick_serializer #(
  parameter int DATA_W        = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   clk_flag,
  tick_serializer_if.slave       bus,
  output logic                   tx_out,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_reg,    state_next;
  logic [TICK_W-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]    bit_cnt_reg,  bit_cnt_next;
  logic [DATA_W-1:0]   shift_reg,    shift_next;
  logic                parity_reg,   parity_next;
  logic                tx_out_reg,   tx_out_next;
  logic                tx_ready_reg, tx_ready_next;
  logic                tx_busy_reg,  tx_busy_next;
  logic                tx_done_reg,  tx_done_next;

  // Parity of the incoming word as an XOR chain; seeding the chain with 1
  // turns even parity into odd parity.
  logic [DATA_W:0] par_chain;
  assign par_chain[0] = (PARITY_ODD != 0);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_parity
      assign par_chain[gi+1] = par_chain[gi] ^ bus.tx_data[gi];
    end
  endgenerate

  // The current bit ends on the strobe that carries the last tick.
  logic bit_end;
  assign bit_end = clk_flag && (tick_cnt_reg == TICK_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_out_reg   <= 1'b1;
      tx_ready_reg <= 1'b1;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_out_reg   <= tx_out_next;
      tx_ready_reg <= tx_ready_next;
      tx_busy_reg  <= tx_busy_next;
      tx_done_reg  <= tx_done_next;
    end
  end

  always_comb begin
    // Without a strobe everything holds, so the defaults are "keep".
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    tx_out_next   = tx_out_reg;
    tx_ready_next = tx_ready_reg;
    tx_busy_next  = tx_busy_reg;
    tx_done_next  = 1'b0;

    // Ticks only advance inside a frame; a strobe on the accept cycle is
    // therefore not counted.
    if (state_reg != IDLE && clk_flag) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt_reg + 1'b1;
    end

    // tx_out is registered, so each branch loads the level of the bit that
    // starts on the following cycle.
    case (state_reg)
      IDLE: begin
        if (bus.tx_valid && tx_ready_reg) begin
          shift_next    = bus.tx_data;
          parity_next   = par_chain[DATA_W];
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = START;
          tx_out_next   = 1'b0;
          tx_busy_next  = 1'b1;
          tx_ready_next = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next  = DATA;
          tx_out_next = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_next  = PARITY;
              tx_out_next = parity_reg;
            end else begin
              state_next  = STOP;
              tx_out_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            tx_out_next  = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next  = STOP;
          tx_out_next = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next    = IDLE;
          tx_out_next   = 1'b1;
          tx_busy_next  = 1'b0;
          tx_ready_next = 1'b1;
          tx_done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.tx_ready = tx_ready_reg;
  assign tx_out       = tx_out_reg;
  assign tx_busy      = tx_busy_reg;
  assign tx_done      = tx_done_reg;

endmodule

// File: tb/tb_tick_serializer.sv
// tb_tick_serializer -- scoreboard bench for tick_serializer.
//
// Five instances cover the parameter corners: default, even parity, odd
// parity, DATA_W = 5 and TICKS_PER_BIT = 1. Stimulus pushes the expected
// frame (hand-computed, bit i = line level of frame bit i) into a per-DUT
// queue; the monitor samples tx_out on every strobe while busy, and on
// tx_done pops and compares the whole frame.
module tb_tick_serializer;

  localparam int NDUT = 5;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic stall0;
  int   div_cnt = 0;

  logic       valid_s [NDUT];
  logic [7:0] data_s  [NDUT];
  logic       flag_w  [NDUT];
  logic       out_w   [NDUT];
  logic       busy_w  [NDUT];
  logic       done_w  [NDUT];
  logic       ready_w [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  frame_t      exp_q     [NDUT][$];
  int          nsamp     [NDUT];
  logic [15:0] got_bits  [NDUT];
  logic        glitch    [NDUT];
  logic        prev_done [NDUT];

  always #5 clk = ~clk;

  function automatic int tpb(input int k);
    case (k)
      0:       return 16;
      1, 2:    return 4;
      default: return 1;
    endcase
  endfunction

  tick_serializer_if #(.DATA_W(8)) if0 ();
  tick_serializer_if #(.DATA_W(8)) if1 ();
  tick_serializer_if #(.DATA_W(8)) if2 ();
  tick_serializer_if #(.DATA_W(5)) if3 ();
  tick_serializer_if #(.DATA_W(8)) if4 ();

  assign if0.tx_valid = valid_s[0];
  assign if1.tx_valid = valid_s[1];
  assign if2.tx_valid = valid_s[2];
  assign if3.tx_valid = valid_s[3];
  assign if4.tx_valid = valid_s[4];
  assign if0.tx_data  = data_s[0];
  assign if1.tx_data  = data_s[1];
  assign if2.tx_data  = data_s[2];
  assign if3.tx_data  = data_s[3][4:0];
  assign if4.tx_data  = data_s[4];
  assign ready_w[0]   = if0.tx_ready;
  assign ready_w[1]   = if1.tx_ready;
  assign ready_w[2]   = if2.tx_ready;
  assign ready_w[3]   = if3.tx_ready;
  assign ready_w[4]   = if4.tx_ready;

  tick_serializer u0 (
    .sys_clk(clk), .sys_rst(rst), .clk_flag(flag_w[0]), .bus(if0.slave),
    .tx_out(out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  tick_serializer #(.TICKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .sys_clk(clk), .sys_rst(rst), .clk_flag(flag_w[1]), .bus(if1.slave),
    .tx_out(out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  tick_serializer #(.TICKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .sys_clk(clk), .sys_rst(rst), .clk_flag(flag_w[2]), .bus(if2.slave),
    .tx_out(out_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );
  tick_serializer #(.DATA_W(5), .TICKS_PER_BIT(1)) u3 (
    .sys_clk(clk), .sys_rst(rst), .clk_flag(flag_w[3]), .bus(if3.slave),
    .tx_out(out_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );
  tick_serializer #(.TICKS_PER_BIT(1)) u4 (
    .sys_clk(clk), .sys_rst(rst), .clk_flag(flag_w[4]), .bus(if4.slave),
    .tx_out(out_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4])
  );

  // Divider model: DUT0 gets one strobe every 6 cycles (gated by stall0),
  // the others are strobed every cycle.
  always @(posedge clk) begin
    #1;
    div_cnt   = (div_cnt == 5) ? 0 : div_cnt + 1;
    flag_w[0] = (div_cnt == 0) && !stall0;
    for (int k = 1; k < NDUT; k++) flag_w[k] = 1'b1;
  end

  task automatic check(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", nm, k, got, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        nsamp[k]     = 0;
        glitch[k]    = 1'b0;
        prev_done[k] = 1'b0;
        got_bits[k]  = '0;
      end else begin
        if (busy_w[k] === 1'b1 && flag_w[k] === 1'b1) begin
          int b;
          b = nsamp[k] / tpb(k);
          if (b < 16) begin
            if ((nsamp[k] % tpb(k)) == 0) got_bits[k][b] = out_w[k];
            else if (out_w[k] !== got_bits[k][b]) glitch[k] = 1'b1;
          end
          nsamp[k]++;
        end
        if (done_w[k] === 1'b1) begin
          check("done_width", k, {31'd0, prev_done[k]}, 32'd0);
          check("ready_at_done", k, {31'd0, ready_w[k]}, 32'd1);
          if (exp_q[k].size() == 0) begin
            check("unexpected_done", k, 32'd1, 32'd0);
          end else begin
            frame_t      e;
            logic [15:0] mask;
            e    = exp_q[k].pop_front();
            mask = 16'((32'd1 << e.n) - 1);
            check("frame_bits", k, {16'd0, got_bits[k] & mask}, {16'd0, e.bits});
            check("frame_strobes", k, nsamp[k], e.n * tpb(k));
            check("bit_steady", k, {31'd0, glitch[k]}, 32'd0);
          end
          $display("frame dut%0d: %0d strobes, bits %0h", k, nsamp[k], got_bits[k]);
          nsamp[k]    = 0;
          glitch[k]   = 1'b0;
          got_bits[k] = '0;
        end
        prev_done[k] = done_w[k];
      end
    end
  end

  // Queue the expected frame (n = 0: frame will be aborted, expect nothing)
  // and present the word until accepted.
  task automatic send(input int k, input logic [7:0] d, input logic [15:0] bits,
                      input int n, input bit hold);
    bit ok;
    frame_t f;
    if (n > 0) begin
      f.bits = bits;
      f.n    = n;
      exp_q[k].push_back(f);
    end
    data_s[k]  = d;
    valid_s[k] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (ready_w[k] === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hold) valid_s[k] = 1'b0;
    check("accept", k, {31'd0, ok}, 32'd1);
    $display("send dut%0d: data %0h", k, d);
  endtask

  task automatic wait_idle(input int k, input bit toggle);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (toggle) data_s[k] = 8'($urandom);
      if (busy_w[k] === 1'b0 && ready_w[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", k, {31'd0, ok}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int errs;
    logic hold_lvl;
    rst    = 1'b1;
    stall0 = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      valid_s[k] = 1'b0;
      data_s[k]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("rst_out", k, {31'd0, out_w[k]}, 32'd1);
      check("rst_ready", k, {31'd0, ready_w[k]}, 32'd1);
      check("rst_busy", k, {31'd0, busy_w[k]}, 32'd0);
      check("rst_done", k, {31'd0, done_w[k]}, 32'd0);
    end
    rst = 1'b0;

    // Idle with strobes running and no valid.
    errs = 0;
    repeat (500) begin
      @(negedge clk);
      if (!(out_w[0] === 1'b1 && ready_w[0] === 1'b1 && busy_w[0] === 1'b0
            && done_w[0] === 1'b0)) errs++;
    end
    check("idle_500", 0, errs, 0);

    // Basic frame 0xA5: line 0,1,0,1,0,0,1,0,1,1.
    send(0, 8'hA5, 16'h34A, 10, 1'b0);
    wait_idle(0, 1'b0);

    // Back-to-back with tx_valid held, then data toggled mid-frame.
    send(0, 8'h3C, 16'h278, 10, 1'b1);
    send(0, 8'hC3, 16'h386, 10, 1'b0);
    check("b2b_start_out", 0, {31'd0, out_w[0]}, 32'd0);
    check("b2b_ready_low", 0, {31'd0, ready_w[0]}, 32'd0);
    wait_idle(0, 1'b1);

    // Stall strobes for 200 cycles mid-DATA.
    send(0, 8'h5A, 16'h2B4, 10, 1'b0);
    repeat (96 * 3 + 40) @(posedge clk);
    @(negedge clk);
    stall0 = 1'b1;
    @(posedge clk); #2;
    hold_lvl = out_w[0];
    errs = 0;
    repeat (200) begin
      @(negedge clk);
      if (out_w[0] !== hold_lvl) errs++;
    end
    check("stall_hold", 0, errs, 0);
    check("stall_busy", 0, {31'd0, busy_w[0]}, 32'd1);
    @(negedge clk);
    stall0 = 1'b0;
    wait_idle(0, 1'b0);

    // Reset mid-frame: aborted, no done.
    send(0, 8'h96, 16'h0, 0, 1'b0);
    repeat (300) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out", 0, {31'd0, out_w[0]}, 32'd1);
    check("midrst_busy", 0, {31'd0, busy_w[0]}, 32'd0);
    check("midrst_ready", 0, {31'd0, ready_w[0]}, 32'd1);
    check("midrst_done", 0, {31'd0, done_w[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    errs = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) errs++;
    end
    check("post_rst_quiet", 0, errs, 0);
    send(0, 8'h81, 16'h302, 10, 1'b0);
    wait_idle(0, 1'b0);

    // Parity and edge-parameter instances.
    send(1, 8'hA5, 16'h54A, 11, 1'b0);
    send(2, 8'hA5, 16'h74A, 11, 1'b0);
    send(3, 8'h15, 16'h06A, 7, 1'b0);
    send(4, 8'hFF, 16'h3FE, 10, 1'b0);
    send(1, 8'h07, 16'h60E, 11, 1'b0);
    for (int k = 1; k < NDUT; k++) wait_idle(k, 1'b0);
    repeat (5) @(negedge clk);

    for (int k = 0; k < NDUT; k++) check("queue_empty", k, exp_q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
